wb_timer: RTL and testbench

Bus-slave programmable down-counter timer for the d16 system, decoded by syscon as a new slave select alongside blkmem0 and uart0. It drives the interrupt input of the d16 CPU, which is currently unconnected. The CPU uses it for periodic ticks and one-shot delays. It has a 16-bit prescaler, a 16-bit counter with auto-reload or one-shot mode, a sticky expiry flag and a maskable interrupt.

---
 rtl/wb_timer.sv | 147 ++++++++++++++
 tb/tb_wb_timer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_timer.sv
// wb_timer: bus-slave programmable down-counter timer.
// A 16-bit prescaler produces ticks that decrement a 16-bit counter. When the
// counter expires it sets a sticky EXP flag and either reloads (periodic mode)
// or stops (one-shot mode). o_int is EXP gated by the IE mask.
module wb_timer #(
  parameter logic [15:0] PRESC_RESET = 16'h0000,
  parameter logic [15:0] LOAD_RESET  = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic [15:0] i_addr,
  input  logic        i_we,
  input  logic        i_cyc,
  output logic        o_int
);

  localparam logic [2:0] AddrCtrl   = 3'd0;
  localparam logic [2:0] AddrPresc  = 3'd1;
  localparam logic [2:0] AddrLoad   = 3'd2;
  localparam logic [2:0] AddrStatus = 3'd3;
  localparam logic [2:0] AddrCount  = 3'd4;

  logic        en_q, en_d;
  logic        reload_q, reload_d;
  logic        ie_q, ie_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] load_q, load_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        exp_q, exp_d;

  logic [2:0] addr;
  logic       wr_en, rd_en;
  logic       wr_ctrl, wr_presc, wr_load, wr_status;
  logic       tick;

  // Upper address bits are decoded by syscon.
  logic unused_addr;
  assign unused_addr = ^i_addr[15:3];

  assign addr      = i_addr[2:0];
  assign wr_en     = i_cyc & i_we;
  assign rd_en     = i_cyc & ~i_we;
  assign wr_ctrl   = wr_en && (addr == AddrCtrl);
  assign wr_presc  = wr_en && (addr == AddrPresc);
  assign wr_load   = wr_en && (addr == AddrLoad);
  assign wr_status = wr_en && (addr == AddrStatus);

  assign tick = en_q && (pcnt_q == 16'd0);

  // Next-state: prescaler, counter, then bus writes layered on top so they win.
  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    exp_d    = exp_q;

    if (en_q) begin
      pcnt_d = tick ? presc_q : pcnt_q - 16'd1;
    end

    if (wr_status && i_dat[0]) begin
      exp_d = 1'b0;
    end

    // A LOAD write swallows the whole tick effect on the counter.
    if (tick && !wr_load) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (reload_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      en_d     = i_dat[0];
      reload_d = i_dat[1];
      ie_d     = i_dat[2];
      if (i_dat[0] && !en_q) begin
        pcnt_d = presc_q;
      end
    end

    if (wr_presc) begin
      presc_d = i_dat;
    end

    if (wr_load) begin
      load_d  = i_dat;
      count_d = i_dat;
      pcnt_d  = presc_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      presc_q  <= PRESC_RESET;
      load_q   <= LOAD_RESET;
      count_q  <= LOAD_RESET;
      pcnt_q   <= PRESC_RESET;
      exp_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      exp_q    <= exp_d;
    end
  end

  // Combinational read mux; zero unless a read cycle is addressed here.
  always_comb begin
    o_dat = 16'h0000;
    if (rd_en) begin
      case (addr)
        AddrCtrl:   o_dat = {13'd0, ie_q, reload_q, en_q};
        AddrPresc:  o_dat = presc_q;
        AddrLoad:   o_dat = load_q;
        AddrStatus: o_dat = {15'd0, exp_q};
        AddrCount:  o_dat = count_q;
        default:    o_dat = 16'h0000;
      endcase
    end
  end

  // Interrupt straight from registers so bus activity cannot glitch it.
  assign o_int = exp_q & ie_q;

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed self-checking bench for wb_timer.
module tb_wb_timer;

  logic        clk;
  logic        reset;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic [15:0] addr;
  logic        we;
  logic        cyc;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  wb_timer #(
    .PRESC_RESET(16'h0000),
    .LOAD_RESET (16'hFFFF)
  ) dut (
    .i_clk  (clk),
    .i_reset(reset),
    .i_dat  (wdat),
    .o_dat  (rdat),
    .i_addr (addr),
    .i_we   (we),
    .i_cyc  (cyc),
    .o_int  (irq)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Bus write: drive on the falling edge, commit on the next rising edge.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cyc  = 1'b1;
    we   = 1'b1;
    addr = {13'd0, a};
    wdat = d;
    @(posedge clk);
    #1;
    cyc  = 1'b0;
    we   = 1'b0;
  endtask

  // Bus read: combinational, sampled 1 time unit after driving.
  task automatic rd(input logic [2:0] a, output logic [15:0] v);
    cyc  = 1'b1;
    we   = 1'b0;
    addr = {13'd0, a};
    #1;
    v    = rdat;
    cyc  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    wr(3'd2, 16'd0);
    wr(3'd0, 16'd7);
    step();
    n_checks++;
    if (irq !== 1'b1) $display("FAIL reset_pre_int: got %b expected 1", irq); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL reset_async_int: got %b expected 0", irq); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0000) $display("FAIL reset_ctrl: got %h expected 0000", v); else n_pass++;
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) $display("FAIL reset_presc: got %h expected 0000", v); else n_pass++;
    rd(3'd2, v); n_checks++;
    if (v !== 16'hFFFF) $display("FAIL reset_load: got %h expected ffff", v); else n_pass++;
    rd(3'd4, v); n_checks++;
    if (v !== 16'hFFFF) $display("FAIL reset_count: got %h expected ffff", v); else n_pass++;
    rd(3'd3, v); n_checks++;
    if (v !== 16'h0000) $display("FAIL reset_status: got %h expected 0000", v); else n_pass++;
  endtask

  task automatic test_periodic();
    logic [15:0] v;
    logic [15:0] exp_cnt [3];
    exp_cnt[0] = 16'd2; exp_cnt[1] = 16'd1; exp_cnt[2] = 16'd0;
    wr(3'd2, 16'd3);
    wr(3'd0, 16'd7);                                   // E0
    rd(3'd4, v); n_checks++;
    if (v !== 16'd3) $display("FAIL periodic_e0_count: got %0d expected 3", v); else n_pass++;
    for (int i = 0; i < 3; i++) begin                  // E1..E3
      step();
      rd(3'd4, v); n_checks++;
      if (v !== exp_cnt[i])
        $display("FAIL periodic_count_e%0d: got %0d expected %0d", i + 1, v, exp_cnt[i]);
      else n_pass++;
    end
    n_checks++;
    if (irq !== 1'b0) $display("FAIL periodic_int_e3: got %b expected 0", irq); else n_pass++;
    step();                                            // E4
    rd(3'd3, v); n_checks++;
    if (v !== 16'd1) $display("FAIL periodic_exp_e4: got %0d expected 1", v); else n_pass++;
    rd(3'd4, v); n_checks++;
    if (v !== 16'd3) $display("FAIL periodic_reload_e4: got %0d expected 3", v); else n_pass++;
    n_checks++;
    if (irq !== 1'b1) $display("FAIL periodic_int_e4: got %b expected 1", irq); else n_pass++;
    wr(3'd3, 16'd1);                                   // E5 clears EXP, count 2
    rd(3'd3, v); n_checks++;
    if (v !== 16'd0) $display("FAIL periodic_clear_e5: got %0d expected 0", v); else n_pass++;
    step(); step();                                    // E6, E7
    rd(3'd3, v); n_checks++;
    if (v !== 16'd0) $display("FAIL periodic_exp_e7: got %0d expected 0", v); else n_pass++;
    step();                                            // E8
    rd(3'd3, v); n_checks++;
    if (v !== 16'd1) $display("FAIL periodic_exp_e8: got %0d expected 1", v); else n_pass++;
    wr(3'd0, 16'd0);                                   // E9: last tick, count 2, stop
    step(); step();
    rd(3'd4, v); n_checks++;
    if (v !== 16'd2) $display("FAIL periodic_freeze: got %0d expected 2", v); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [15:0] v;
    wr(3'd3, 16'd1);
    wr(3'd1, 16'd4);
    wr(3'd2, 16'd1);
    wr(3'd0, 16'd5);                                   // enable edge
    for (int i = 0; i < 9; i++) step();
    rd(3'd3, v); n_checks++;
    if (v !== 16'd0) $display("FAIL oneshot_early_exp: got %0d expected 0", v); else n_pass++;
    step();                                            // 10 cycles after enable
    rd(3'd3, v); n_checks++;
    if (v !== 16'd1) $display("FAIL oneshot_exp: got %0d expected 1", v); else n_pass++;
    rd(3'd0, v); n_checks++;
    if (v !== 16'd4) $display("FAIL oneshot_ctrl: got %h expected 0004", v); else n_pass++;
    n_checks++;
    if (irq !== 1'b1) $display("FAIL oneshot_int: got %b expected 1", irq); else n_pass++;
    for (int i = 0; i < 50; i++) begin
      step();
      rd(3'd4, v); n_checks++;
      if (v !== 16'd0) $display("FAIL oneshot_hold_%0d: got %0d expected 0", i, v); else n_pass++;
    end
  endtask

  task automatic test_clear_race();
    logic [15:0] v;
    wr(3'd3, 16'd1);
    wr(3'd1, 16'd0);
    wr(3'd2, 16'd1);
    wr(3'd0, 16'd7);                                   // E0
    step();                                            // E1: count 0
    wr(3'd3, 16'd1);                                   // E2: expiry and clear collide
    rd(3'd3, v); n_checks++;
    if (v !== 16'd1) $display("FAIL race_exp_kept: got %0d expected 1", v); else n_pass++;
    rd(3'd4, v); n_checks++;
    if (v !== 16'd1) $display("FAIL race_reload: got %0d expected 1", v); else n_pass++;
    wr(3'd3, 16'd1);                                   // E3: lone clear
    rd(3'd3, v); n_checks++;
    if (v !== 16'd0) $display("FAIL race_lone_clear: got %0d expected 0", v); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL race_int_drop: got %b expected 0", irq); else n_pass++;
    wr(3'd0, 16'd2);                                   // E4: expiry, IE off, EN off
    rd(3'd3, v); n_checks++;
    if (v !== 16'd1) $display("FAIL mask_exp: got %0d expected 1", v); else n_pass++;
    n_checks++;
    if (irq !== 1'b0) $display("FAIL mask_int: got %b expected 0", irq); else n_pass++;
    wr(3'd0, 16'd4);
    n_checks++;
    if (irq !== 1'b1) $display("FAIL unmask_int: got %b expected 1", irq); else n_pass++;
    wr(3'd3, 16'd1);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL clear_int: got %b expected 0", irq); else n_pass++;
  endtask

  task automatic test_load_collision();
    logic [15:0] v;
    wr(3'd2, 16'd20);
    wr(3'd0, 16'd3);                                   // E0
    step(); step();                                    // E1, E2
    rd(3'd4, v); n_checks++;
    if (v !== 16'd18) $display("FAIL coll_pre: got %0d expected 18", v); else n_pass++;
    wr(3'd2, 16'd10);                                  // E3: load beats tick
    rd(3'd4, v); n_checks++;
    if (v !== 16'd10) $display("FAIL coll_load: got %0d expected 10", v); else n_pass++;
    step();                                            // E4
    rd(3'd4, v); n_checks++;
    if (v !== 16'd9) $display("FAIL coll_dec1: got %0d expected 9", v); else n_pass++;
    step();                                            // E5
    wr(3'd0, 16'd0);                                   // E6: last tick then stop
    rd(3'd4, v); n_checks++;
    if (v !== 16'd7) $display("FAIL coll_stop: got %0d expected 7", v); else n_pass++;
  endtask

  task automatic test_bus_decode();
    logic [15:0] v;
    @(negedge clk);
    cyc  = 1'b0;
    we   = 1'b1;
    addr = 16'd2;
    wdat = 16'h1234;
    #1;
    n_checks++;
    if (rdat !== 16'h0000) $display("FAIL decode_idle_dat: got %h expected 0000", rdat); else n_pass++;
    step();
    we = 1'b0;
    rd(3'd2, v); n_checks++;
    if (v !== 16'd10) $display("FAIL decode_nocyc_write: got %0d expected 10", v); else n_pass++;
    wr(3'd4, 16'h0055);
    rd(3'd4, v); n_checks++;
    if (v !== 16'd7) $display("FAIL decode_count_ro: got %0d expected 7", v); else n_pass++;
    for (int a = 5; a < 8; a++) begin
      wr(3'(a), 16'hFFFF);
      rd(3'(a), v); n_checks++;
      if (v !== 16'h0000) $display("FAIL decode_addr%0d: got %h expected 0000", a, v); else n_pass++;
    end
    rd(3'd1, v); n_checks++;
    if (v !== 16'h0000) $display("FAIL decode_presc_kept: got %h expected 0000", v); else n_pass++;
    wr(3'd0, 16'hFFF0);
    rd(3'd0, v); n_checks++;
    if (v !== 16'h0000) $display("FAIL decode_ctrl_bits: got %h expected 0000", v); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    wdat  = 16'h0000;
    addr  = 16'h0000;
    we    = 1'b0;
    cyc   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_clear_race();
    test_load_collision();
    test_bus_decode();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
